// File: rtl/lsu_mem_if.sv
// Load/store unit: one request/acknowledge access to data memory per load or store, with byte strobes and load extension.
// Defining LSU_TIMEOUT_EN bounds the request phase to TIMEOUT cycles and ends it with an error pulse.
module lsu_mem_if #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       load_data,
   output logic              load_valid,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state;
   logic [2:0]  size_q;
   logic [1:0]  off_q;
   logic        illegal;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] shifted;
   logic [31:0] load_next;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      illegal = 1'b0;
      case (req_size)
         3'b000:  illegal = 1'b0;
         3'b001:  illegal = req_addr[0];
         3'b010:  illegal = (req_addr[1:0] != 2'b00);
         3'b100:  illegal = req_we;
         3'b101:  illegal = req_we | req_addr[0];
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = req_wdata;
      case (req_size[1:0])
         2'b00: begin
            be_next    = 4'b0001 << req_addr[1:0];
            wdata_next = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << req_addr[1:0];
            wdata_next = {2{req_wdata[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = req_wdata;
         end
      endcase
   end

   // Extraction uses the registered offset/size so a changing req_addr cannot corrupt the result.
   always_comb begin
      shifted   = mem_rdata >> {off_q, 3'b000};
      load_next = mem_rdata;
      case (size_q)
         3'b000:  load_next = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_next = {24'h0, shifted[7:0]};
         3'b001:  load_next = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_next = {16'h0, shifted[15:0]};
         default: load_next = mem_rdata;
      endcase
   end

   assign stall = (state == REQ) || ((state == IDLE) && req_valid);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         size_q     <= 3'b000;
         off_q      <= 2'b00;
         load_valid <= 1'b0;
         err        <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= 32'h0;
         load_data  <= 32'h0;
`ifdef LSU_TIMEOUT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         load_valid <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (illegal) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     state     <= REQ;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_be    <= be_next;
                     mem_wdata <= wdata_next;
                     size_q    <= req_size;
                     off_q     <= req_addr[1:0];
`ifdef LSU_TIMEOUT_EN
                     wait_cnt  <= '0;
`endif
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!mem_we) begin
                     load_data  <= load_next;
                     load_valid <= 1'b1;
                  end
                  state <= DONE;
`ifdef LSU_TIMEOUT_EN
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  err     <= 1'b1;
                  state   <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Randomized bench for lsu_mem_if: a byte-lane reference model predicts strobes, write data, load data and errors.
// The timeout scenario follows LSU_TIMEOUT_EN when it is defined.
module tb_lsu_mem_if;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              req_valid, req_we;
   logic [2:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              stall, load_valid, err, mem_req, mem_we, mem_ack;
   logic [31:0]       load_data, mem_wdata, mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;

   int n_vec = 0;
   int n_err = 0;

   lsu_mem_if #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .load_data(load_data), .load_valid(load_valid), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: access width in bytes, 0 for an undefined size.
   function automatic int nbytes(input logic [2:0] sz);
      case (sz)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit model_illegal(input bit we, input logic [2:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      if (n == 0) return 1'b1;
      if (we && sz[2]) return 1'b1;
      return (a % n) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] sz, input logic [31:0] a);
      logic [3:0] be = '0;
      int off = int'(a % 4);
      for (int i = 0; i < 4; i++)
         if (i >= off && i < off + nbytes(sz)) be[i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] wd);
      logic [31:0] r = '0;
      int n = nbytes(sz);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a,
                                              input logic [31:0] rd);
      longint val = 0;
      int n   = nbytes(sz);
      int off = int'(a % 4);
      if (n == 4) return rd;
      for (int k = 0; k < n; k++) val += longint'(rd[8*(off+k) +: 8]) << (8*k);
      if (!sz[2] && val >= (longint'(1) << (8*n - 1))) val -= longint'(1) << (8*n);
      return val[31:0];
   endfunction

   // One full instruction: IDLE cycle, then REQ cycles (ack after dly waits) and DONE, or the error path.
   task automatic txn(input bit we, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int dly);
      bit bad = model_illegal(we, sz, a);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
      mem_ack = 1'b0;
      @(negedge clk);
      check("idle_stall", {31'h0, stall}, 32'h1);
      check("idle_req", {31'h0, mem_req}, 32'h0);
      if (bad) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("err_pulse", {31'h0, err}, 32'h1);
         check("err_stall", {31'h0, stall}, 32'h0);
         check("err_req", {31'h0, mem_req}, 32'h0);
         check("err_lv", {31'h0, load_valid}, 32'h0);
      end else begin
         for (int w = 0; w <= dly; w++) begin
            @(posedge clk); #1;
            mem_ack   = (w == dly);
            mem_rdata = (w == dly) ? rd : $urandom;
            @(negedge clk);
            check("req_req", {31'h0, mem_req}, 32'h1);
            check("req_stall", {31'h0, stall}, 32'h1);
            check("req_we", {31'h0, mem_we}, {31'h0, we});
            check("req_addr", mem_addr, {a[31:2], 2'b00});
            check("req_be", {28'h0, mem_be}, {28'h0, model_be(sz, a)});
            if (we) check("req_wdata", mem_wdata, model_wdata(sz, wd));
            check("req_err", {31'h0, err}, 32'h0);
         end
         @(posedge clk); #1;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         @(negedge clk);
         check("done_lv", {31'h0, load_valid}, {31'h0, !we});
         if (!we) check("done_data", load_data, model_load(sz, a, rd));
         check("done_err", {31'h0, err}, 32'h0);
         check("done_stall", {31'h0, stall}, 32'h0);
         check("done_req", {31'h0, mem_req}, 32'h0);
      end
      // Gap cycle in IDLE with a stray ack that must be ignored.
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("gap_req", {31'h0, mem_req}, 32'h0);
      check("gap_stall", {31'h0, stall}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit dropped;
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
      req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_req", {31'h0, mem_req}, 32'h0);
      check("rst_be", {28'h0, mem_be}, 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_ld", load_data, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      reset_n = 1'b1;

      txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);  // LB
      txn(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 1);  // SH
      txn(1'b0, 3'b101, 32'h002, 32'h0, 32'h8001_0000, 4);  // LHU, 4 wait cycles
      txn(1'b0, 3'b010, 32'h005, 32'h0, 32'h0, 0);          // misaligned LW
      txn(1'b1, 3'b100, 32'h010, 32'h0, 32'h0, 0);          // store with BU size
      txn(1'b0, 3'b111, 32'h010, 32'h0, 32'h0, 0);          // undefined size

      // Reset pulled mid-access.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h40;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_req_before", {31'h0, mem_req}, 32'h1);
      #2;
      reset_n = 1'b0; req_valid = 1'b0;
      #1;
      check("mid_rst_req", {31'h0, mem_req}, 32'h0);
      check("mid_rst_stall", {31'h0, stall}, 32'h0);
      check("mid_rst_be", {28'h0, mem_be}, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      txn(1'b0, 3'b010, 32'h44, 32'h0, 32'hDEAD_BEEF, 2);

      for (int t = 0; t < 300; t++) begin
         logic [31:0] a = $urandom;
         logic [2:0]  sz;
         // Bias toward legal sizes so most transactions reach memory.
         case ($urandom_range(0, 5))
            0:       sz = 3'b000;
            1:       sz = 3'b001;
            2:       sz = 3'b010;
            3:       sz = 3'b100;
            4:       sz = 3'b101;
            default: sz = 3'($urandom);
         endcase
         if ($urandom_range(0, 3) != 0 && nbytes(sz) != 0) a = a & ~(32'(nbytes(sz)) - 32'h1);
         txn(1'($urandom), sz, a, $urandom, $urandom, $urandom_range(0, 6));
      end

      // Memory that never answers.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h80; mem_ack = 1'b0;
      @(negedge clk);
      cnt = 0;
      dropped = 1'b0;
`ifdef LSU_TIMEOUT_EN
      for (int c = 0; c < 40 && !dropped; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (mem_req) cnt++;
         else dropped = 1'b1;
      end
      check("to_req_cycles", 32'(cnt), 32'(TIMEOUT));
      check("to_err", {31'h0, err}, 32'h1);
      check("to_lv", {31'h0, load_valid}, 32'h0);
`else
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (mem_req) cnt++;
      end
      check("noto_req_cycles", 32'(cnt), 32'd20);
      check("noto_err", {31'h0, err}, 32'h0);
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      check("noto_lv", {31'h0, load_valid}, 32'h1);
      check("noto_data", load_data, 32'h1234_5678);
`endif
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
